id_ex_skid_reg: RTL and testbench
=================================

ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

Interface
REQ-001 Parameters: DATA_W, default 32, width of readdata1/readdata2/Immediate/data2/PC.
REQ-002 Parameters: REG_AW, default 5, destination register address width.
REQ-003 Parameters: CMD_W, default 4, EXE_Cmd width; BR_W, default 2, BR_Type width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  ID stage presents a decoded instruction.
REQ-007 in_ready  out  1  block can accept; registered, equals (state != FULL).
REQ-008 flush  in  1  synchronous kill of all held and incoming instructions (taken branch).
REQ-009 dest_in  in  REG_AW; readdata1_in, readdata2_in, Immediate_in, data2_in, PC_in  in  DATA_W each.
REQ-010 WB_En_in, MEM_R_En_in, MEM_W_En_in  in  1 each; BR_Type_in  in  BR_W; EXE_Cmd_in  in  CMD_W.
REQ-011 out_valid  out  1  EXE-side entry valid; out_ready  in  1  EXE stage consumes.
REQ-012 dest, readdata1, readdata2, Immediate, data2, PC, WB_En, MEM_R_En, MEM_W_En, BR_Type, EXE_Cmd  out  widths mirror inputs.
REQ-013 occupancy  out  2  number of held entries (0..2).

Function
REQ-014 Two payload entries SHALL exist: main (drives outputs) and skid; in_fire = in_valid&in_ready, out_fire = out_valid&out_ready.
REQ-015 States SHALL be EMPTY (occupancy 0), ONE (1), FULL (2); out_valid = (state != EMPTY).
REQ-016 EMPTY: in_fire -> ONE, main <= inputs; else stay.
REQ-017 ONE: in_fire&out_fire -> ONE, main <= inputs; in_fire only -> FULL, skid <= inputs; out_fire only -> EMPTY; neither -> hold.
REQ-018 FULL: out_fire -> ONE, main <= skid; else hold; no input accepted (in_ready=0).
REQ-019 Latency SHALL be one cycle: payload accepted at edge N is on outputs after edge N when EMPTY or ONE with out_fire.
REQ-020 Throughput SHALL be one instruction per cycle while out_ready stays high.
REQ-021 in_ready SHALL depend only on registered state, never combinationally on out_ready.
REQ-022 flush SHALL override all other events: next state EMPTY, both entries discarded, a same-cycle in_fire dropped.
REQ-023 When out_valid=0, WB_En, MEM_R_En, MEM_W_En SHALL be 0 and BR_Type, EXE_Cmd all-zero (bubble); data outputs hold last main value.
REQ-024 Payload in an entry SHALL remain stable while that entry is held (no update without a transfer).
REQ-025 in_valid while in_ready=0 SHALL have no effect; upstream holds its payload.

Reset
REQ-026 rst high SHALL immediately force state EMPTY, occupancy 0, in_ready 1, out_valid 0, all payload registers and outputs 0.
REQ-027 Reset asserted mid-transfer SHALL discard both entries; first acceptance after release occurs on the first edge with rst low.

Structure
REQ-028 State encoding (EMPTY/ONE/FULL) and default widths SHALL live in the shared pipeline package.
REQ-029 One sub-module SHALL be used: pipe_payload_reg, a parametrised enable-loaded register holding one full payload, instantiated twice.

Verification
REQ-030 Reset: assert rst asynchronously mid-cycle with FULL -> outputs zero, in_ready=1, occupancy=0 before next edge.
REQ-031 Streaming: out_ready=1, PC_in 0x0,0x4,0x8 on 3 cycles -> outputs PC 0x0,0x4,0x8 one cycle later each, occupancy stays 1.
REQ-032 Backpressure: out_ready=0, send PC 0x10,0x14,0x18 -> first two held (occupancy 2, in_ready 0), 0x18 not accepted; out_ready=1 -> 0x10,0x14 out in order.
REQ-033 Flush: FULL with WB_En=1 entries, flush=1 with in_valid=1 -> next cycle out_valid=0, WB_En=0, EXE_Cmd=0, occupancy 0.
REQ-034 Simultaneous: ONE state, in_fire and out_fire same edge, PC 0x20 held, PC_in 0x24 -> PC=0x24, occupancy 1.
REQ-035 Parameters: DATA_W=64, REG_AW=6 instance passes REQ-031 with PC 0xFFFF_FFFF_FFFF_FFFC unaltered.

Source files
------------

// File: rtl/id_ex_skid_reg_pkg.sv
// rtl/id_ex_skid_reg_pkg.sv - shared pipeline state encoding and default widths
package id_ex_skid_reg_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_CMD_W  = 4;
  localparam int DEF_BR_W   = 2;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - enable-loaded register holding one pipeline payload
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_skid_reg.sv
// rtl/id_ex_skid_reg.sv - two-entry ID/EX skid register with flush and bubble gating
module id_ex_skid_reg
  import id_ex_skid_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CMD_W  = DEF_CMD_W,
  parameter int BR_W   = DEF_BR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [DATA_W-1:0] readdata1_in,
  input  logic [DATA_W-1:0] readdata2_in,
  input  logic [DATA_W-1:0] Immediate_in,
  input  logic [DATA_W-1:0] data2_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic              WB_En_in,
  input  logic              MEM_R_En_in,
  input  logic              MEM_W_En_in,
  input  logic [BR_W-1:0]   BR_Type_in,
  input  logic [CMD_W-1:0]  EXE_Cmd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] dest,
  output logic [DATA_W-1:0] readdata1,
  output logic [DATA_W-1:0] readdata2,
  output logic [DATA_W-1:0] Immediate,
  output logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] PC,
  output logic              WB_En,
  output logic              MEM_R_En,
  output logic              MEM_W_En,
  output logic [BR_W-1:0]   BR_Type,
  output logic [CMD_W-1:0]  EXE_Cmd,
  output logic [1:0]        occupancy
);

  localparam int PAY_W = REG_AW + 5 * DATA_W + 3 + BR_W + CMD_W;

  skid_state_e      state_q, state_d;
  logic [PAY_W-1:0] in_pay, main_d, main_q, skid_q;
  logic             main_ld, skid_ld, main_from_skid;
  logic             in_fire, out_fire;
  logic             wb_q, mr_q, mw_q;
  logic [BR_W-1:0]  br_q;
  logic [CMD_W-1:0] cmd_q;

  assign in_pay = {dest_in, readdata1_in, readdata2_in, Immediate_in, data2_in, PC_in,
                   WB_En_in, MEM_R_En_in, MEM_W_En_in, BR_Type_in, EXE_Cmd_in};

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_ld = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pay;

  pipe_payload_reg #(.W(PAY_W)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_ld),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_payload_reg #(.W(PAY_W)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_ld),
    .d    (in_pay),
    .q    (skid_q)
  );

  assign {dest, readdata1, readdata2, Immediate, data2, PC, wb_q, mr_q, mw_q, br_q, cmd_q} = main_q;

  // Control fields become a bubble when nothing is valid; data fields keep the last main value.
  assign WB_En    = wb_q & out_valid;
  assign MEM_R_En = mr_q & out_valid;
  assign MEM_W_En = mw_q & out_valid;
  assign BR_Type  = out_valid ? br_q : '0;
  assign EXE_Cmd  = out_valid ? cmd_q : '0;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// tb/tb_id_ex_skid_reg.sv - scoreboard bench for id_ex_skid_reg against a queue model
module tb_id_ex_skid_reg;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] rd1, rd2, imm, d2, pc;
    logic        wb, mr, mw;
    logic [1:0]  br;
    logic [3:0]  cmd;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic  in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  item_t din = '0;
  logic  in_ready, out_valid;
  logic [4:0]  dest;
  logic [31:0] readdata1, readdata2, Immediate, data2, PC;
  logic        WB_En, MEM_R_En, MEM_W_En;
  logic [1:0]  BR_Type;
  logic [3:0]  EXE_Cmd;
  logic [1:0]  occupancy;
  item_t dout;

  int errors = 0;
  int checks = 0;

  id_ex_skid_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .dest_in(din.dest), .readdata1_in(din.rd1), .readdata2_in(din.rd2), .Immediate_in(din.imm),
    .data2_in(din.d2), .PC_in(din.pc), .WB_En_in(din.wb), .MEM_R_En_in(din.mr),
    .MEM_W_En_in(din.mw), .BR_Type_in(din.br), .EXE_Cmd_in(din.cmd),
    .out_valid(out_valid), .out_ready(out_ready), .dest(dest), .readdata1(readdata1),
    .readdata2(readdata2), .Immediate(Immediate), .data2(data2), .PC(PC), .WB_En(WB_En),
    .MEM_R_En(MEM_R_En), .MEM_W_En(MEM_W_En), .BR_Type(BR_Type), .EXE_Cmd(EXE_Cmd),
    .occupancy(occupancy)
  );

  assign dout = {dest, readdata1, readdata2, Immediate, data2, PC, WB_En, MEM_R_En, MEM_W_En, BR_Type, EXE_Cmd};

  logic        v64 = 1'b0;
  logic [63:0] pc64 = '0;
  logic [63:0] z64 = '0;
  logic        in_ready64, out_valid64, wb64, mr64, mw64;
  logic [5:0]  dest64;
  logic [63:0] rd1_64, rd2_64, imm64, d2_64, pc64_o;
  logic [1:0]  br64, occ64;
  logic [3:0]  cmd64;

  id_ex_skid_reg #(.DATA_W(64), .REG_AW(6)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(in_ready64), .flush(1'b0),
    .dest_in(6'd0), .readdata1_in(z64), .readdata2_in(z64), .Immediate_in(z64),
    .data2_in(z64), .PC_in(pc64), .WB_En_in(1'b1), .MEM_R_En_in(1'b0),
    .MEM_W_En_in(1'b0), .BR_Type_in(2'd0), .EXE_Cmd_in(4'd0),
    .out_valid(out_valid64), .out_ready(1'b1), .dest(dest64), .readdata1(rd1_64),
    .readdata2(rd2_64), .Immediate(imm64), .data2(d2_64), .PC(pc64_o), .WB_En(wb64),
    .MEM_R_En(mr64), .MEM_W_En(mw64), .BR_Type(br64), .EXE_Cmd(cmd64),
    .occupancy(occ64)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of held instructions, at most two deep.
  item_t sb[$];
  item_t last_main = '0;

  always @(posedge clk or posedge rst) begin
    int n;
    if (rst) begin
      sb.delete();
      last_main = '0;
    end else begin
      n = sb.size();
      if (flush) begin
        sb.delete();
      end else begin
        if (n > 0 && out_ready) void'(sb.pop_front());
        if (in_valid && n < 2) sb.push_back(din);
      end
      if (sb.size() > 0) last_main = sb[0];
    end
  end

  always @(negedge clk) begin
    item_t exp_bubble;
    if (!rst) begin
      chk("occupancy", occupancy, sb.size());
      chk("in_ready", in_ready, sb.size() < 2);
      chk("out_valid", out_valid, sb.size() > 0);
      if (sb.size() > 0) begin
        chk("payload", dout, sb[0]);
      end else begin
        exp_bubble = last_main;
        exp_bubble.wb = 1'b0;
        exp_bubble.mr = 1'b0;
        exp_bubble.mw = 1'b0;
        exp_bubble.br = '0;
        exp_bubble.cmd = '0;
        chk("bubble", dout, exp_bubble);
      end
    end
  end

  function automatic item_t mk(input logic [31:0] pc);
    item_t it;
    it.dest = 5'($urandom);
    it.rd1  = $urandom;
    it.rd2  = $urandom;
    it.imm  = $urandom;
    it.d2   = $urandom;
    it.pc   = pc;
    it.wb   = 1'b1;
    it.mr   = 1'($urandom);
    it.mw   = 1'($urandom);
    it.br   = 2'($urandom);
    it.cmd  = 4'($urandom_range(1, 15));
    return it;
  endfunction

  task automatic cyc(input logic v, input logic fl, input logic r, input item_t it);
    in_valid  = v;
    flush     = fl;
    out_ready = r;
    din       = it;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_outputs", dout, '0);
    rst = 1'b0;

    cyc(1, 0, 1, mk(32'h0));
    cyc(1, 0, 1, mk(32'h4));
    cyc(1, 0, 1, mk(32'h8));
    chk("stream_pc", PC, 32'h8);
    cyc(0, 0, 1, mk(32'h0));

    cyc(1, 0, 0, mk(32'h10));
    cyc(1, 0, 0, mk(32'h14));
    cyc(1, 0, 0, mk(32'h18));
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_pc_head", PC, 32'h10);
    cyc(0, 0, 1, mk(32'h0));
    chk("bp_pc_next", PC, 32'h14);
    cyc(0, 0, 1, mk(32'h0));

    cyc(1, 0, 0, mk(32'h30));
    cyc(1, 0, 0, mk(32'h34));
    cyc(1, 1, 0, mk(32'h38));
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_wb", WB_En, 1'b0);
    chk("flush_cmd", EXE_Cmd, 4'd0);
    chk("flush_occ", occupancy, 2'd0);

    cyc(1, 0, 0, mk(32'h20));
    cyc(1, 0, 1, mk(32'h24));
    chk("simul_pc", PC, 32'h24);
    chk("simul_occ", occupancy, 2'd1);
    cyc(0, 0, 1, mk(32'h0));

    cyc(1, 0, 0, mk(32'h40));
    cyc(1, 0, 0, mk(32'h44));
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("arst_occ", occupancy, 2'd0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_outputs", dout, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 0, 0, mk(32'h50));
    chk("post_rst_pc", PC, 32'h50);

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
          mk($urandom));
    end
    cyc(0, 0, 1, mk(32'h0));
    cyc(0, 0, 1, mk(32'h0));

    v64  = 1'b1;
    pc64 = 64'h0;
    @(posedge clk);
    #1;
    chk("w64_pc0", pc64_o, 64'h0);
    pc64 = 64'h4;
    @(posedge clk);
    #1;
    chk("w64_pc1", pc64_o, 64'h4);
    chk("w64_occ", occ64, 2'd1);
    pc64 = 64'hFFFF_FFFF_FFFF_FFFC;
    @(posedge clk);
    #1;
    chk("w64_pc2", pc64_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w64_valid", out_valid64, 1'b1);
    chk("w64_wb", wb64, 1'b1);
    v64 = 1'b0;
    @(posedge clk);
    #1;
    chk("w64_drain", out_valid64, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
